// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the CPU / sprite-DMA bus arbiter.
// Holds the FSM state encoding, the trigger/target addresses and the bus bundle types.
package oam_dma_arbiter_pkg;

    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_PORT = 16'h2004;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HALT,
        S_ALIGN,
        S_RD,
        S_WR
    } state_t;

    typedef struct packed {
        logic r;
        logic w;
    } strobe_t;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        strobe_t     s;
    } bus_t;

    // States in which the DMA engine, not the core, owns the bus.
    function automatic logic owns_bus(state_t st);
        return st inside {S_HALT, S_ALIGN, S_RD, S_WR};
    endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// Core-side and memory-side bus signals of the arbiter, bundled with modports.
// slave = the arbiter itself, master = whatever drives the core side and returns read data.
interface oam_dma_arbiter_if;
    logic        ce;
    logic [15:0] cpu_A;
    logic [7:0]  cpu_D;
    logic        cpu_R;
    logic        cpu_W;
    logic        cpu_m0;
    logic        cpu_ce;
    logic [15:0] A;
    logic [7:0]  D;
    logic        R;
    logic        W;
    logic [7:0]  I;
    logic        busy;

    modport slave (
        input  ce, cpu_A, cpu_D, cpu_R, cpu_W, cpu_m0, I,
        output cpu_ce, A, D, R, W, busy
    );

    modport master (
        output ce, cpu_A, cpu_D, cpu_R, cpu_W, cpu_m0, I,
        input  cpu_ce, A, D, R, W, busy
    );
endinterface

// File: rtl/oam_dma_arbiter_bus_mux.sv
// Selects which requester drives the shared A/D/R/W bus.
module oam_dma_arbiter_bus_mux
    import oam_dma_arbiter_pkg::*;
(
    input  logic sel,
    input  bus_t cpu_bus,
    input  bus_t dma_bus,
    output bus_t out_bus
);

    assign out_bus = sel ? dma_bus : cpu_bus;

endmodule

// File: rtl/oam_dma_arbiter.sv
// Shares the CPU bus between the 6502 core and the sprite OAM DMA engine.
// A write to DMA_REG freezes the core at its next opcode fetch and copies one page to OAM_PORT.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    oam_dma_arbiter_if.slave  bus
);

    state_t     state, state_nx;
    logic [7:0] page, lo, buf_q;
    logic       parity;
    logic       cpu_ce;
    logic       dma_trig;
    bus_t       cpu_bus, dma_bus, out_bus;

    assign dma_trig = bus.cpu_W && (bus.cpu_A == DMA_REG);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // parity free-runs on ce so an odd-aligned stall can be detected at HALT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            page   <= '0;
            lo     <= '0;
            buf_q  <= '0;
            parity <= 1'b0;
        end else if (bus.ce) begin
            parity <= ~parity;
            case (state)
                S_IDLE: if (dma_trig) begin
                    page <= bus.cpu_D;
                    lo   <= '0;
                end
                S_RD:   buf_q <= bus.I;
                S_WR:   if (lo != 8'hFF) lo <= lo + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        cpu_ce     = 1'b0;
        dma_bus.a  = {page, lo};
        dma_bus.d  = buf_q;
        dma_bus.s  = '0;
        unique case (state)
            S_IDLE: begin
                cpu_ce = bus.ce;
                if (bus.ce && dma_trig) state_nx = S_WAIT;
            end
            S_WAIT: begin
                // Core keeps running until it reaches an opcode fetch.
                cpu_ce = bus.ce && !bus.cpu_m0;
                if (bus.ce && bus.cpu_m0) state_nx = S_HALT;
            end
            S_HALT: if (bus.ce) state_nx = parity ? S_ALIGN : S_RD;
            S_ALIGN: if (bus.ce) state_nx = S_RD;
            S_RD: begin
                dma_bus.s.r = 1'b1;
                if (bus.ce) state_nx = S_WR;
            end
            S_WR: begin
                dma_bus.a   = OAM_PORT;
                dma_bus.s.w = 1'b1;
                if (bus.ce) state_nx = (lo == 8'hFF) ? S_IDLE : S_RD;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign cpu_bus.a   = bus.cpu_A;
    assign cpu_bus.d   = bus.cpu_D;
    assign cpu_bus.s.r = bus.cpu_R;
    assign cpu_bus.s.w = bus.cpu_W;

    oam_dma_arbiter_bus_mux u_mux (
        .sel     (owns_bus(state)),
        .cpu_bus (cpu_bus),
        .dma_bus (dma_bus),
        .out_bus (out_bus)
    );

    assign bus.A      = out_bus.a;
    assign bus.D      = out_bus.d;
    assign bus.R      = out_bus.s.r;
    assign bus.W      = out_bus.s.w;
    assign bus.cpu_ce = cpu_ce;
    assign bus.busy   = (state != S_IDLE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized bench for oam_dma_arbiter: a memory model supplies read data and the expected
// DMA traffic is derived from the page contents, the ce-tick count and the transfer rules.
module tb_oam_dma_arbiter;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   n_tick = 0;
    logic [7:0] mem [0:65535];

    oam_dma_arbiter_if bus ();

    oam_dma_arbiter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    assign bus.I = mem[bus.A];

    // ce ticks since reset; its lsb is the expected parity.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)    n_tick <= 0;
        else if (bus.ce) n_tick <= n_tick + 1;
    end

    task automatic drive(input logic cv, input logic [15:0] a, input logic [7:0] d,
                         input logic r, input logic w, input logic m0);
        bus.ce     = cv;
        bus.cpu_A  = a;
        bus.cpu_D  = d;
        bus.cpu_R  = r;
        bus.cpu_W  = w;
        bus.cpu_m0 = m0;
    endtask

    task automatic test_reset();
        drive(1'b1, 16'h1234, 8'hAB, 1'b1, 1'b0, 1'b0);
        #2;
        total++;
        if (bus.busy !== 1'b0 || bus.cpu_ce !== 1'b1 || bus.A !== 16'h1234 ||
            bus.D !== 8'hAB || bus.R !== 1'b1 || bus.W !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b cpu_ce=%b A=%h D=%h R=%b W=%b want 0 1 1234 ab 1 0",
                     bus.busy, bus.cpu_ce, bus.A, bus.D, bus.R, bus.W);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_pass_through();
        logic [15:0] a;
        logic [7:0]  d;
        logic        cv, r, w;
        for (int k = 0; k < 10; k++) begin
            a  = (k == 0) ? 16'h1234 : 16'($urandom_range(0, 16'h3fff));
            d  = 8'($urandom);
            cv = (k == 0) ? 1'b1 : 1'($urandom);
            r  = (k == 0) ? 1'b1 : 1'($urandom);
            w  = (k == 0) ? 1'b0 : ~r;
            drive(cv, a, d, r, w, 1'($urandom));
            @(negedge clock);
            total++;
            if (bus.A !== a || bus.D !== d || bus.R !== r || bus.W !== w ||
                bus.cpu_ce !== cv || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL pass_through: got A=%h D=%h R=%b W=%b cpu_ce=%b busy=%b want %h %h %b %b %b 0",
                         bus.A, bus.D, bus.R, bus.W, bus.cpu_ce, bus.busy, a, d, r, w, cv);
            end
            @(posedge clock); #1;
        end
    endtask

    // One full (or aborted) transfer. want_par = parity at the HALT tick.
    task automatic do_dma(input logic [7:0] page, input int want_par,
                          input int wait_ticks, input int abort_after);
        int          stall, nwr, nrd, dummy;
        bit          done, aborted;
        logic [15:0] a, last_rd;
        logic        cv;
        stall = 0; nwr = 0; nrd = 0; dummy = 0;
        done = 1'b0; aborted = 1'b0; last_rd = '0;

        drive(1'b1, 16'h4014, page, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        total++;
        if (bus.A !== 16'h4014 || bus.W !== 1'b1 || bus.D !== page ||
            bus.cpu_ce !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL trigger_write: got A=%h W=%b D=%h cpu_ce=%b busy=%b want 4014 1 %h 1 0",
                     bus.A, bus.W, bus.D, bus.cpu_ce, bus.busy, page);
        end
        @(posedge clock); #1;

        for (int k = 0; k < wait_ticks; k++) begin
            a  = 16'($urandom_range(0, 16'h3fff));
            cv = 1'($urandom);
            drive(cv, a, 8'($urandom), 1'b1, 1'b0, 1'b0);
            @(negedge clock);
            total++;
            if (bus.cpu_ce !== cv || bus.A !== a || bus.R !== 1'b1 ||
                bus.W !== 1'b0 || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL wait_pass: got cpu_ce=%b A=%h R=%b W=%b busy=%b want %b %h 1 0 1",
                         bus.cpu_ce, bus.A, bus.R, bus.W, bus.busy, cv, a);
            end
            @(posedge clock); #1;
        end

        while ((n_tick % 2) == want_par) begin
            drive(1'b1, 16'h8000, 8'h00, 1'b1, 1'b0, 1'b0);
            @(posedge clock); #1;
        end

        drive(1'b1, 16'h8000, 8'h00, 1'b1, 1'b0, 1'b1);
        @(negedge clock);
        total++;
        if (bus.cpu_ce !== 1'b0 || bus.A !== 16'h8000 || bus.R !== 1'b1) begin
            bad++;
            $display("FAIL m0_gate: got cpu_ce=%b A=%h R=%b want 0 8000 1", bus.cpu_ce, bus.A, bus.R);
        end
        @(posedge clock); #1;

        for (int c = 0; c < 3000 && !done && !aborted; c++) begin
            a  = 16'($urandom_range(0, 16'h3fff));
            cv = ($urandom_range(0, 3) != 0);
            drive(cv, a, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge clock);
            if (bus.busy === 1'b0) begin
                done = 1'b1;
                total++;
                if (bus.cpu_ce !== cv || bus.A !== a) begin
                    bad++;
                    $display("FAIL resume: got cpu_ce=%b A=%h want %b %h", bus.cpu_ce, bus.A, cv, a);
                end
            end else begin
                total++;
                if (bus.cpu_ce !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_cpu_ce: got %b want 0", bus.cpu_ce);
                end
                if (cv) begin
                    stall++;
                    total++;
                    if (bus.W === 1'b1) begin
                        if (bus.A !== 16'h2004 || bus.R !== 1'b0 || nwr != nrd - 1 ||
                            bus.D !== mem[{page, 8'(nwr)}]) begin
                            bad++;
                            $display("FAIL oam_write%0d: got A=%h R=%b D=%h want 2004 0 %h",
                                     nwr, bus.A, bus.R, bus.D, mem[{page, 8'(nwr)}]);
                        end
                        nwr++;
                    end else if (bus.R === 1'b1) begin
                        if (bus.A !== {page, 8'(nrd)} || nwr != nrd) begin
                            bad++;
                            $display("FAIL dma_read%0d: got A=%h want %h", nrd, bus.A, {page, 8'(nrd)});
                        end
                        last_rd = bus.A;
                        nrd++;
                    end else begin
                        if (bus.A !== {page, 8'h00} || nrd != 0) begin
                            bad++;
                            $display("FAIL dummy_cycle: got A=%h after %0d reads want %h", bus.A, nrd, {page, 8'h00});
                        end
                        dummy++;
                    end
                end
                if (abort_after > 0 && nwr == abort_after) begin
                    #2 reset_n = 1'b0;
                    #1;
                    total++;
                    if (bus.busy !== 1'b0 || bus.cpu_ce !== cv || bus.A !== a) begin
                        bad++;
                        $display("FAIL abort: got busy=%b cpu_ce=%b A=%h want 0 %b %h",
                                 bus.busy, bus.cpu_ce, bus.A, cv, a);
                    end
                    #1 reset_n = 1'b1;
                    aborted = 1'b1;
                end
            end
            @(posedge clock); #1;
        end

        if (!aborted) begin
            total++;
            if (!done) begin
                bad++;
                $display("FAIL timeout: got busy=1 want 0 within 3000 cycles");
            end
            total++;
            if (stall != 513 + want_par) begin
                bad++;
                $display("FAIL stall_ticks: got %0d want %0d", stall, 513 + want_par);
            end
            total++;
            if (nwr != 256 || nrd != 256) begin
                bad++;
                $display("FAIL xfer_count: got rd=%0d wr=%0d want 256 256", nrd, nwr);
            end
            total++;
            if (dummy != 1 + want_par) begin
                bad++;
                $display("FAIL dummy_count: got %0d want %0d", dummy, 1 + want_par);
            end
            total++;
            if (last_rd !== {page, 8'hFF}) begin
                bad++;
                $display("FAIL last_read: got %h want %h", last_rd, {page, 8'hFF});
            end
        end
    endtask

    task automatic test_even_dma();
        do_dma(8'h02, 0, 0, 0);
    endtask

    task automatic test_odd_dma();
        do_dma(8'h02, 1, 0, 0);
    endtask

    task automatic test_late_stall();
        do_dma(8'h20, 0, 12, 0);
    endtask

    task automatic test_page_wrap();
        do_dma(8'hFF, 1, 3, 0);
    endtask

    task automatic test_abort();
        do_dma(8'h03, 0, 2, 100);
        do_dma(8'h03, 1, 1, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
        test_reset();
        test_pass_through();
        test_even_dma();
        test_odd_dma();
        test_late_stall();
        test_page_wrap();
        test_abort();
        test_pass_through();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
